// File: rtl/wb_burst_master_q.sv
// Queued Wishbone B4 burst master: command FIFO, linear/wrap bursts, ERR/timeout abort with write drain.
// Optional statistics counters are built when WB_BURST_MASTER_STATS_EN is defined.
module wb_burst_master_q #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [WB_ADDR_WIDTH-1:0]    cmd_adr,
  input  logic                        cmd_we,
  input  logic [WB_DATA_WIDTH/8-1:0]  cmd_sel,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic [1:0]                  cmd_bte,
  input  logic                        wdat_valid,
  output logic                        wdat_ready,
  input  logic [WB_DATA_WIDTH-1:0]    wdat_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]    rsp_data,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  output logic                        rsp_last,
  output logic [WB_ADDR_WIDTH-1:0]    ADR,
  output logic [WB_DATA_WIDTH-1:0]    DAT_W,
  input  logic [WB_DATA_WIDTH-1:0]    DAT_R,
  output logic                        CYC,
  output logic                        STB,
  output logic                        WE,
  output logic [WB_DATA_WIDTH/8-1:0]  SEL,
  output logic [2:0]                  CTI,
  output logic [1:0]                  BTE,
  input  logic                        ACK,
  input  logic                        ERR
`ifdef WB_BURST_MASTER_STATS_EN
  ,
  output logic [31:0]                 stat_cmds,
  output logic [15:0]                 stat_errs,
  output logic [15:0]                 stat_tmos,
  output logic [31:0]                 stat_beats
`endif
);
  localparam int AW    = WB_ADDR_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int LW    = $clog2(MAX_BURST);
  localparam int PW    = $clog2(CMD_DEPTH);
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] BEAT  = 3'd3;
  localparam logic [2:0] RSPW  = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;

  typedef struct packed {
    logic [AW-1:0]    adr;
    logic             we;
    logic [BYTES-1:0] sel;
    logic [LW-1:0]    len;
    logic [1:0]       bte;
  } cmd_t;

  cmd_t          fifo_q [CMD_DEPTH];
  logic [PW:0]   wp_q, rp_q;
  logic          full, empty, push, pop;
  cmd_t          head;

  assign full      = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign empty     = (wp_q == rp_q);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_q[rp_q[PW-1:0]];

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    datw_q, datw_d;
  logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [BYTES-1:0] sel_q, sel_d;
  logic [2:0]       cti_q, cti_d;
  logic [1:0]       bte_q, bte_d, wrap_q, wrap_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             len0_q, len0_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             rv_q, rv_d, rerr_q, rerr_d, rtmo_q, rtmo_d, rlast_q, rlast_d;
  logic [DW-1:0]    rdat_q, rdat_d;
  logic             slot_ok, ack_ev, err_ev, tmo_ev, done_ev;

  assign pop     = (state_q == LOAD);
  // The response slot must be empty after the edge that raises STB, since ACK cannot be refused.
  assign slot_ok = !rv_q || rsp_ready;
  assign ack_ev  = stb_q && ACK && !ERR;
  assign err_ev  = stb_q && ERR;
  assign tmo_ev  = (TIMEOUT_CYCLES != 0) && stb_q && !ACK && !ERR &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign done_ev = ack_ev || err_ev || tmo_ev;

  assign wdat_ready = ((state_q == WDATA) && slot_ok) || (state_q == DRAIN);

  function automatic logic [2:0] cti_f(input logic len0, input logic [LW-1:0] cnt);
    return len0 ? 3'b000 : ((cnt == '0) ? 3'b111 : 3'b010);
  endfunction

  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] b);
    logic [AW-1:0] m;
    case (b)
      2'b01:   m = AW'(4 * BYTES - 1);
      2'b10:   m = AW'(8 * BYTES - 1);
      2'b11:   m = AW'(16 * BYTES - 1);
      default: m = '1;
    endcase
    return (a & ~m) | ((a + AW'(BYTES)) & m);
  endfunction

  always_comb begin
    state_d = state_q; adr_d = adr_q; datw_d = datw_q; cyc_d = cyc_q; stb_d = stb_q;
    we_d = we_q; sel_d = sel_q; cti_d = cti_q; bte_d = bte_q; wrap_d = wrap_q;
    cnt_d = cnt_q; len0_d = len0_q;
    rv_d = rv_q && !rsp_ready; rdat_d = rdat_q; rerr_d = rerr_q; rtmo_d = rtmo_q; rlast_d = rlast_q;
    tmo_d = (stb_q && !ACK && !ERR && !tmo_ev) ? tmo_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: begin
        adr_d = head.adr; we_d = head.we; sel_d = head.sel; wrap_d = head.bte;
        cnt_d = head.len; len0_d = (head.len == '0);
        if (head.we) state_d = WDATA;
        else begin
          cyc_d = 1'b1; stb_d = slot_ok; bte_d = head.bte;
          cti_d = cti_f(head.len == '0, head.len);
          state_d = slot_ok ? BEAT : RSPW;
        end
      end
      WDATA: if (wdat_valid && slot_ok) begin
        datw_d = wdat_data; cyc_d = 1'b1; stb_d = 1'b1; bte_d = wrap_q;
        cti_d = cti_f(len0_q, cnt_q); state_d = BEAT;
      end
      RSPW: if (slot_ok) begin
        stb_d = 1'b1; cti_d = cti_f(len0_q, cnt_q); state_d = BEAT;
      end
      BEAT: if (done_ev) begin
        stb_d = 1'b0;
        if (!ack_ev) begin
          cyc_d = 1'b0; cti_d = 3'b000; bte_d = 2'b00;
          rv_d = 1'b1; rdat_d = '0; rerr_d = err_ev; rtmo_d = tmo_ev; rlast_d = 1'b1;
          state_d = (we_q && cnt_q != '0) ? DRAIN : IDLE;
        end else begin
          adr_d = next_adr(adr_q, wrap_q); cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            cyc_d = 1'b0; cti_d = 3'b000; bte_d = 2'b00;
            rv_d = 1'b1; rdat_d = we_q ? '0 : DAT_R; rerr_d = 1'b0; rtmo_d = 1'b0; rlast_d = 1'b1;
            state_d = IDLE;
          end else if (we_q) begin
            state_d = WDATA;
          end else begin
            rv_d = 1'b1; rdat_d = DAT_R; rerr_d = 1'b0; rtmo_d = 1'b0; rlast_d = 1'b0;
            state_d = RSPW;
          end
        end
      end
      DRAIN: if (wdat_valid) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) if (push) fifo_q[wp_q[PW-1:0]] <= '{cmd_adr, cmd_we, cmd_sel, cmd_len, cmd_bte};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0; rp_q <= '0; state_q <= IDLE; adr_q <= '0; datw_q <= '0;
      cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0; sel_q <= '0; cti_q <= '0; bte_q <= '0;
      wrap_q <= '0; cnt_q <= '0; len0_q <= 1'b0; tmo_q <= '0;
      rv_q <= 1'b0; rdat_q <= '0; rerr_q <= 1'b0; rtmo_q <= 1'b0; rlast_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      state_q <= state_d; adr_q <= adr_d; datw_q <= datw_d;
      cyc_q <= cyc_d; stb_q <= stb_d; we_q <= we_d; sel_q <= sel_d; cti_q <= cti_d; bte_q <= bte_d;
      wrap_q <= wrap_d; cnt_q <= cnt_d; len0_q <= len0_d; tmo_q <= tmo_d;
      rv_q <= rv_d; rdat_q <= rdat_d; rerr_q <= rerr_d; rtmo_q <= rtmo_d; rlast_q <= rlast_d;
    end
  end

  assign ADR = adr_q;  assign DAT_W = datw_q; assign CYC = cyc_q; assign STB = stb_q;
  assign WE  = we_q;   assign SEL = sel_q;    assign CTI = cti_q; assign BTE = bte_q;
  assign rsp_valid = rv_q; assign rsp_data = rdat_q; assign rsp_err = rerr_q;
  assign rsp_timeout = rtmo_q; assign rsp_last = rlast_q;

`ifdef WB_BURST_MASTER_STATS_EN
  logic cmd_done;
  assign cmd_done = (state_q == BEAT) && done_ev && (!ack_ev || cnt_q == '0);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cmds <= '0; stat_errs <= '0; stat_tmos <= '0; stat_beats <= '0;
    end else begin
      if (cmd_done && !(&stat_cmds))  stat_cmds  <= stat_cmds + 1'b1;
      if (err_ev   && !(&stat_errs))  stat_errs  <= stat_errs + 1'b1;
      if (tmo_ev   && !(&stat_tmos))  stat_tmos  <= stat_tmos + 1'b1;
      if (ack_ev   && !(&stat_beats)) stat_beats <= stat_beats + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_burst_master_q.sv
// Scoreboard bench for wb_burst_master_q: issued commands push expected bus beats and responses,
// a slave model and a response monitor pop and compare independently.
module tb_wb_burst_master_q;
  localparam int TMO = 16;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid = 0, cmd_ready, cmd_we = 0, wdat_valid = 0, wdat_ready;
  logic [31:0] cmd_adr = 0, wdat_data = 0, rsp_data, ADR, DAT_W, DAT_R = 0;
  logic [3:0] cmd_sel = 0, SEL;
  logic [2:0] cmd_len = 0, CTI;
  logic [1:0] cmd_bte = 0, BTE;
  logic rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout, rsp_last;
  logic CYC, STB, WE, ACK = 0, ERR = 0;

  wb_burst_master_q #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .CMD_DEPTH(4), .MAX_BURST(8),
                      .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_len(cmd_len), .cmd_bte(cmd_bte),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_last(rsp_last), .ADR(ADR), .DAT_W(DAT_W), .DAT_R(DAT_R),
    .CYC(CYC), .STB(STB), .WE(WE), .SEL(SEL), .CTI(CTI), .BTE(BTE), .ACK(ACK), .ERR(ERR));

  // kind: 0 ACK, 1 ERR, 2 no answer (timeout), 3 ACK+ERR
  typedef struct {
    logic [31:0] adr; logic [2:0] cti; logic we; logic [3:0] sel; logic [31:0] dat;
    logic [1:0] bte; int kind; int wt; logic [31:0] rdata;
  } beat_t;
  typedef struct { logic [31:0] data; logic err, tmo, last; } rsp_t;

  beat_t bq[$];
  rsp_t  rq[$];
  logic [31:0] wdq[$];
  int nchk = 0, nerr = 0, acks = 0;
  bit hold = 0, b_act = 0, tmo_act = 0;
  int tmo_cnt = 0, wcnt = 0;
  beat_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nchk++; nerr++;
    $display("FAIL %s", nm);
  endtask

  // Address of beat k: linear step, or offset modulo the wrap span inside its aligned block.
  function automatic logic [31:0] beat_adr(input logic [31:0] a, input logic [1:0] b, input int k);
    logic [31:0] sp, base;
    if (b == 2'b00) return a + 32'(4 * k);
    sp   = 32'(4 * (2 << b));
    base = a - (a % sp);
    return base + (((a - base) + 32'(4 * k)) % sp);
  endfunction

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s, input int len,
                       input logic [1:0] b, input int ab, input int ak, input int wt, input bit fx);
    int n = 0;
    bit ok = 0;
    logic [31:0] wd [8];
    beat_t bt;
    rsp_t r;
    while (!ok && n < 500) begin
      @(negedge clk);
      cmd_valid = 1; cmd_adr = a; cmd_we = w; cmd_sel = s; cmd_len = 3'(len); cmd_bte = b;
      #1;
      if (cmd_ready) ok = 1;
      n++;
    end
    if (!ok) begin
      fail("cmd_accept_timeout");
      cmd_valid = 0;
      return;
    end
    for (int k = 0; k <= len; k++) wd[k] = fx ? 32'(k + 1) : $urandom;
    for (int k = 0; k <= len; k++) begin
      if (ab >= 0 && k > ab) break;
      bt.adr = beat_adr(a, b, k);
      bt.cti = (len == 0) ? 3'b000 : ((k == len) ? 3'b111 : 3'b010);
      bt.we = w; bt.sel = s; bt.dat = w ? wd[k] : 32'h0; bt.bte = b;
      bt.kind = (k == ab) ? ak : 0;
      bt.wt = (wt < 0) ? int'($urandom_range(0, 2)) : wt;
      bt.rdata = (fx && k == 0) ? 32'hDEADBEEF : $urandom;
      bq.push_back(bt);
      if (!w) begin
        r.data = (bt.kind == 0) ? bt.rdata : 32'h0;
        r.err = (bt.kind == 1 || bt.kind == 3);
        r.tmo = (bt.kind == 2);
        r.last = (k == len) || (bt.kind != 0);
        rq.push_back(r);
      end
    end
    if (w) begin
      r.data = 32'h0; r.err = (ab >= 0) && (ak == 1 || ak == 3);
      r.tmo = (ab >= 0) && (ak == 2); r.last = 1'b1;
      rq.push_back(r);
      for (int k = 0; k <= len; k++) wdq.push_back(wd[k]);
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 3000 && !(bq.size() == 0 && rq.size() == 0 && wdq.size() == 0 &&
                         !CYC && !tmo_act && !b_act)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail("idle_wait_timeout");
  endtask

  // Slave model: checks each beat when STB first rises, then answers per the planned kind.
  always @(negedge clk) begin
    ACK = 0; ERR = 0;
    if (rstn) begin
      if (tmo_act) begin
        if (STB) tmo_cnt++;
        else begin
          chk("tmo_stb_cycles", 64'(tmo_cnt), 64'(TMO));
          tmo_act = 0;
        end
      end else if (STB) begin
        if (!b_act) begin
          if (bq.size() == 0) begin
            fail("unexpected_beat");
            ACK = 1;
          end else begin
            cur = bq.pop_front();
            chk("beat_adr", 64'(ADR), 64'(cur.adr));
            chk("beat_cti", 64'(CTI), 64'(cur.cti));
            chk("beat_bte", 64'(BTE), 64'(cur.bte));
            chk("beat_we_sel", {59'h0, WE, SEL}, {59'h0, cur.we, cur.sel});
            if (cur.we) chk("beat_datw", 64'(DAT_W), 64'(cur.dat));
            if (cur.kind == 2) begin
              tmo_act = 1; tmo_cnt = 1;
            end else begin
              b_act = 1; wcnt = cur.wt;
            end
          end
        end
        if (b_act) begin
          if (wcnt > 0) wcnt--;
          else begin
            ACK = (cur.kind == 0 || cur.kind == 3);
            ERR = (cur.kind == 1 || cur.kind == 3);
            DAT_R = cur.rdata;
            b_act = 0;
            acks++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wdq.size() > 0 && $urandom_range(0, 3) != 0) begin
      wdat_valid = 1; wdat_data = wdq[0];
    end else wdat_valid = 0;
    #1;
    if (wdat_valid && wdat_ready) void'(wdq.pop_front());
  end

  always @(negedge clk) begin
    rsp_t e;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) fail("unexpected_rsp");
      else begin
        e = rq.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_err_tmo_last", {61'h0, rsp_err, rsp_timeout, rsp_last}, {61'h0, e.err, e.tmo, e.last});
      end
    end
  end

  initial begin
    int a0, ab, ak, ln, r;
    #22;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_bus", {56'h0, CYC, STB, WE, CTI, BTE}, 64'h0);
    chk("rst_adr_sel", {28'h0, ADR, SEL}, 64'h0);
    chk("rst_rsp_wdat", {58'h0, rsp_valid, rsp_err, rsp_timeout, rsp_last, wdat_ready, 1'b0}, 64'h0);
    @(negedge clk) rstn = 1;

    // single read, 2 wait states, latency to CYC
    wait_idle();
    issue(32'h100, 0, 4'hF, 0, 2'b00, -1, 0, 2, 1);
    @(negedge clk);
    @(negedge clk); chk("lat_cyc_n1", 64'(CYC), 64'd0);
    @(negedge clk); chk("lat_cyc_n2", 64'(CYC), 64'd1);
    // linear write burst, wrap4 read, ERR on beat 2 of a write followed by a read
    issue(32'h200, 1, 4'hF, 3, 2'b00, -1, 0, 0, 1);
    issue(32'h38, 0, 4'hF, 3, 2'b01, -1, 0, 0, 0);
    issue(32'h400, 1, 4'hF, 3, 2'b00, 1, 1, 0, 0);
    issue(32'h500, 0, 4'h3, 1, 2'b00, -1, 0, -1, 0);
    wait_idle();
    issue(32'h600, 0, 4'hF, 0, 2'b00, 0, 2, 0, 0);
    wait_idle();

    // response backpressure with a full command queue
    hold = 1; a0 = acks;
    for (int i = 0; i < 5; i++) issue(32'h1000 + 32'(i * 64), 0, 4'hF, 3, 2'b00, -1, 0, 0, 0);
    repeat (20) @(negedge clk);
    chk("bp_beats_le1", 64'((acks - a0) <= 1), 64'd1);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    hold = 0;
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      ln = $urandom_range(0, 7);
      r = $urandom_range(0, 19);
      ab = -1; ak = 0;
      if (r < 4) begin
        ab = $urandom_range(0, ln);
        ak = (r < 2) ? 1 : ((r == 2) ? 3 : 2);
      end
      issue({14'h0, 16'($urandom), 2'b00}, 1'($urandom), 4'($urandom_range(1, 15)), ln,
            2'($urandom), ab, ak, -1, 0);
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end
endmodule
